// File: rtl/cmp_max_ctrl.sv
// Sequencer that streams N_WORDS 2-bit samples through one shared external magnitude
// comparator and reports the maximum value and the index of its first occurrence.
module cmp_max_ctrl #(
    parameter int N_WORDS = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       in_data,
    output logic             in_ready,
    output logic [1:0]       cmp_a,
    output logic [1:0]       cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic             err
);

    // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready depends only on state, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_ACCEPT = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // One extra bit so that count can reach N_WORDS even when N_WORDS == 2**IDX_W.
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(N_WORDS);

    state_t         state;
    state_t         state_nxt;
    logic [IDX_W:0] count;
    logic [IDX_W:0] count_inc;
    logic [2:0]     flags;
    logic           flag_gt;
    logic           flag_ok;
    logic           accept;

    assign accept    = in_valid & in_ready;
    assign count_inc = count + (IDX_W+1)'(1);
    assign flags     = {cmp_gt, cmp_eq, cmp_lt};
    assign flag_gt   = (flags == 3'b100);
    assign flag_ok   = flag_gt || (flags == 3'b010) || (flags == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)  state_nxt = S_FIRST;
            S_FIRST:  if (accept) state_nxt = S_ACCEPT;
            S_ACCEPT: if (accept) state_nxt = S_EVAL;
            S_EVAL:   state_nxt = (count_inc == LAST) ? S_DONE : S_ACCEPT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE:   ;
            S_FIRST:  begin in_ready = 1'b1; busy = 1'b1; end
            S_ACCEPT: begin in_ready = 1'b1; busy = 1'b1; end
            default:  busy = 1'b1;
        endcase
    end

    // cmp_a doubles as the candidate register while the comparator settles in EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            max_val <= '0;
            max_idx <= '0;
            cmp_a   <= '0;
            cmp_b   <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        count <= '0;
                    end
                end
                S_FIRST: begin
                    if (accept) begin
                        max_val <= in_data;
                        max_idx <= '0;
                        count   <= (IDX_W+1)'(1);
                    end
                end
                S_ACCEPT: begin
                    if (accept) begin
                        cmp_a <= in_data;
                        cmp_b <= max_val;
                    end
                end
                S_EVAL: begin
                    // Only a strict greater-than moves the max, so ties keep the earlier index.
                    if (flag_gt) begin
                        max_val <= cmp_a;
                        max_idx <= count[IDX_W-1:0];
                    end
                    if (!flag_ok) begin
                        err <= 1'b1;
                    end
                    count <= count_inc;
                    done  <= (count_inc == LAST);
                end
                default: ;
            endcase
        end
    end

endmodule
